multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main FSM for the multi-cycle MIPS core. Sequences one shared ALU, memory port and register file across FETCH/DECODE/EXEC/MEM/WB.
//  Drives alu_op[2:0] to alu_control; 3'b111 hands ALU selection to the R-type function-code decode.
//  Sits between the instruction register (opcode) and the datapath muxes and write enables.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready before bus_error; 0 = wait forever
// PORTS
//  clk            in   1  clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   6  IR[31:26]; valid from DECODE onward
//  zero           in   1  ALU zero flag
//  mem_ready      in   1  memory done; completes current mem_req
//  alu_op         out  3  to alu_control (ALUOP_* codes, 3'b111 = R-type)
//  alu_src_a      out  1  0 = PC, 1 = reg A
//  alu_src_b      out  2  0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
//  pc_src         out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if zero
//  iord           out  1  memory address: 0 = PC, 1 = ALUOut
//  mem_req        out  1  memory request, held until mem_ready
//  mem_we         out  1  write qualifier for mem_req
//  ir_write       out  1  load IR (only on the FETCH cycle with mem_ready=1)
//  reg_write      out  1  register file write
//  reg_dst        out  1  0 = rt, 1 = rd
//  mem_to_reg     out  1  0 = ALUOut, 1 = MDR
//  illegal_op     out  1  1-cycle pulse on unknown opcode
//  bus_error      out  1  1-cycle pulse on memory timeout
//  state          out  4  current state (debug)
// BEHAVIOUR
//  Moore outputs decoded from state. Exception: ir_write and pc_write in FETCH are qualified by mem_ready.
//  Reset (async, any cycle incl. mid-MEM): state=S_FETCH, timeout counter=0. All outputs 0 while rst_n=0.
//  S_FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. Stay until mem_ready.
//    On mem_ready: ir_write=1, pc_write=1, then go to S_DECODE.
//  S_DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Next state by opcode:
//    R 6'h00 -> S_EXEC_R; lw 6'h23 / sw 6'h2B -> S_ADDR; beq 6'h04 -> S_BRANCH;
//    addi 6'h08 / slti 6'h0A / andi 6'h0C / ori 6'h0D -> S_EXEC_I; j 6'h02 -> S_JUMP;
//    any other opcode -> illegal_op pulse, then S_FETCH.
//  S_EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=3'b111 -> S_WB_R. S_WB_R: reg_write=1, reg_dst=1 -> S_FETCH.
//  S_EXEC_I: alu_src_a=1, alu_src_b=2, alu_op = ADD/SLT/AND/OR per opcode -> S_WB_I.
//    S_WB_I: reg_write=1, reg_dst=0 -> S_FETCH.
//  S_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD -> S_MEM.
//  S_MEM: mem_req=1, iord=1, mem_we=(opcode==sw). Stay until mem_ready. Then lw -> S_WB_MEM, sw -> S_FETCH.
//  S_WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 -> S_FETCH.
//  S_BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_src=1 -> S_FETCH.
//  S_JUMP: pc_write=1, pc_src=2 -> S_FETCH.
//  Latency with 0-wait memory: R/I 4 cycles, lw 5, sw 4, beq 3, j 3.
//  Timeout: counter clears on entry to S_FETCH/S_MEM and increments each cycle without mem_ready.
//    At MEM_TIMEOUT: bus_error pulse, goto S_FETCH with no PC/IR/reg write (fetch retries same PC).
//    mem_ready on the same cycle as the count reaches the limit wins: normal completion, no error.
//  opcode is sampled combinationally every cycle. IR must hold stable from DECODE to the end of the instruction.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
//    cycle_cnt increments every cycle out of reset. instr_cnt increments on each ir_write.
//    Both wrap at 2^32 and reset to 0.
//  Not defined: neither port nor counter exists; all other behaviour identical.
// STRUCTURE
//  Package mips_ctrl_pkg: state encodings S_* (4-bit); opcode constants OP_*;
//    ALUOP_ADD/SUB/AND/OR/SLT plus ALUOP_RTYPE=3'b111 matching alu_control encoding.
//  One sub-module, mem_wait_timer: timeout counter, clear/enable inputs, expire output.
//  FSM next-state and output decode live in this module.
// TESTING
//  1 R-type add, mem_ready=1 always -> state FETCH,DECODE,EXEC_R,WB_R; alu_op=3'b111 in EXEC_R;
//    reg_write=1, reg_dst=1 on cycle 4.
//  2 lw with mem_ready delayed 3 cycles in S_MEM -> mem_req held 4 cycles, iord=1, mem_we=0;
//    then WB_MEM with mem_to_reg=1.
//  3 beq, zero=1 -> S_BRANCH with pc_write_cond=1, pc_src=1, alu_op=SUB; back to FETCH 3 cycles after start.
//  4 opcode 6'h3F -> illegal_op high exactly 1 cycle after DECODE; FETCH next; no reg_write or pc_write.
//  5 mem_ready held 0 in FETCH, MEM_TIMEOUT=16 -> bus_error pulse after 16 cycles; no ir_write; FETCH re-entered.
//  6 rst_n dropped mid-S_MEM of sw -> outputs 0 immediately; after release state=FETCH, mem_we=0, counters 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit: FSM state
// encodings, instruction opcodes, ALU operation codes driven to alu_control,
// the bundle of decoded control outputs and an I-type ALU-op helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // 4-bit state encoding, also exported on the debug state output.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_WB_R    = 4'd3,
        S_EXEC_I  = 4'd4,
        S_WB_I    = 4'd5,
        S_ADDR    = 4'd6,
        S_MEM     = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ILLEGAL = 4'd11  // one cycle holding illegal_op, then refetch
    } state_e;

    // IR[31:26] opcodes handled by the core.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation codes as understood by alu_control.
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_SLT   = 3'b100;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;  // defer to funct decode

    // Decoded control outputs (everything except state and bus_error).
    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_out_t;

    // ALU operation for the immediate arithmetic/logic instructions.
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_SLTI: return ALUOP_SLT;
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Control bundle between the multi-cycle control FSM and the datapath.
//   master (control unit): in  opcode[5:0], zero, mem_ready
//                          out alu_op[2:0], alu_src_a, alu_src_b[1:0],
//                              pc_src[1:0], pc_write, pc_write_cond, iord,
//                              mem_req, mem_we, ir_write, reg_write, reg_dst,
//                              mem_to_reg, illegal_op, bus_error, state[3:0]
//   slave (datapath):      the same signals with directions reversed.
// Macro MC_PERF_CNT_EN adds cycle_cnt[31:0] and instr_cnt[31:0] (master out).
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic        pc_write;
    logic        pc_write_cond;
    logic        iord;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        illegal_op;
    logic        bus_error;
    logic [3:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond,
        output iord, mem_req, mem_we, ir_write, reg_write, reg_dst, mem_to_reg,
        output illegal_op, bus_error, state
`ifdef MC_PERF_CNT_EN
        , output cycle_cnt, instr_cnt
`endif
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond,
        input  iord, mem_req, mem_we, ir_write, reg_write, reg_dst, mem_to_reg,
        input  illegal_op, bus_error, state
`ifdef MC_PERF_CNT_EN
        , input cycle_cnt, instr_cnt
`endif
    );
endinterface

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on the memory port and flags expiry on the
// LIMIT-th consecutive wait cycle. LIMIT = 0 disables expiry (wait forever).
//   clk       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   i_clr     in  clear counter (wins over i_en)
//   i_en      in  a wait cycle: count it
//   o_expire  out this wait cycle is the LIMIT-th; counter self-clears
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CntW-1:0] LastCnt = (LIMIT > 0) ? CntW'(LIMIT - 1) : '0;

    logic [CntW-1:0] r_cnt;

    // Counter holds the number of wait cycles already elapsed, so the cycle
    // that sees LastCnt is the LIMIT-th one.
    assign o_expire = (LIMIT != 0) && i_en && (r_cnt == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_expire) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main FSM of the multi-cycle MIPS core. Sequences the shared ALU, memory port
// and register file through FETCH/DECODE/EXEC/MEM/WB.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset; all outputs 0 while low
//   bus    multicycle_control_if.master: opcode/zero/mem_ready in, datapath
//          mux selects, write enables, mem_req/mem_we, illegal_op and
//          bus_error pulses and debug state out.
// Parameter MEM_TIMEOUT: wait cycles on mem_ready before bus_error (0 = never).
// Macro MC_PERF_CNT_EN: adds cycle_cnt/instr_cnt free-running counters.
// -----------------------------------------------------------------------------
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    state_e    r_state;
    state_e    w_state_nxt;
    ctrl_out_t w_out;
    logic      w_in_wait;
    logic      w_tmr_en;
    logic      w_tmr_clr;
    logic      w_expire;
    logic      r_bus_error;

    // Only FETCH and MEM wait on memory; leaving them (or completing) clears
    // the count so each entry starts from zero.
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_tmr_en  = w_in_wait && !bus.mem_ready;
    assign w_tmr_clr = !w_tmr_en;

    mem_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_error <= w_expire;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out       = '0;
        case (r_state)
            S_FETCH: begin
                w_out.mem_req   = 1'b1;
                w_out.alu_src_b = 2'd1;
                w_out.alu_op    = ALUOP_ADD;
                // IR/PC load only once the instruction word is actually there.
                if (bus.mem_ready) begin
                    w_out.ir_write = 1'b1;
                    w_out.pc_write = 1'b1;
                    w_state_nxt    = S_DECODE;
                end else if (w_expire) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                w_out.alu_src_b = 2'd3;
                w_out.alu_op    = ALUOP_ADD;
                case (bus.opcode)
                    OP_RTYPE:                         w_state_nxt = S_EXEC_R;
                    OP_LW, OP_SW:                     w_state_nxt = S_ADDR;
                    OP_BEQ:                           w_state_nxt = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_state_nxt = S_EXEC_I;
                    OP_J:                             w_state_nxt = S_JUMP;
                    default:                          w_state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                w_out.alu_src_a = 1'b1;
                w_out.alu_src_b = 2'd0;
                w_out.alu_op    = ALUOP_RTYPE;
                w_state_nxt     = S_WB_R;
            end
            S_WB_R: begin
                w_out.reg_write = 1'b1;
                w_out.reg_dst   = 1'b1;
                w_state_nxt     = S_FETCH;
            end
            S_EXEC_I: begin
                w_out.alu_src_a = 1'b1;
                w_out.alu_src_b = 2'd2;
                w_out.alu_op    = imm_alu_op(bus.opcode);
                w_state_nxt     = S_WB_I;
            end
            S_WB_I: begin
                w_out.reg_write = 1'b1;
                w_state_nxt     = S_FETCH;
            end
            S_ADDR: begin
                w_out.alu_src_a = 1'b1;
                w_out.alu_src_b = 2'd2;
                w_out.alu_op    = ALUOP_ADD;
                w_state_nxt     = S_MEM;
            end
            S_MEM: begin
                w_out.mem_req = 1'b1;
                w_out.iord    = 1'b1;
                w_out.mem_we  = (bus.opcode == OP_SW);
                if (bus.mem_ready) begin
                    w_state_nxt = (bus.opcode == OP_LW) ? S_WB_MEM : S_FETCH;
                end else if (w_expire) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_WB_MEM: begin
                w_out.reg_write  = 1'b1;
                w_out.mem_to_reg = 1'b1;
                w_state_nxt      = S_FETCH;
            end
            S_BRANCH: begin
                w_out.alu_src_a     = 1'b1;
                w_out.alu_src_b     = 2'd0;
                w_out.alu_op        = ALUOP_SUB;
                w_out.pc_write_cond = 1'b1;
                w_out.pc_src        = 2'd1;
                w_state_nxt         = S_FETCH;
            end
            S_JUMP: begin
                w_out.pc_write = 1'b1;
                w_out.pc_src   = 2'd2;
                w_state_nxt    = S_FETCH;
            end
            S_ILLEGAL: begin
                w_out.illegal_op = 1'b1;
                w_state_nxt      = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase
        // FETCH is state 0 but drives mem_req; force silence during reset.
        if (!rst_n) begin
            w_out = '0;
        end
    end

    assign bus.alu_op        = w_out.alu_op;
    assign bus.alu_src_a     = w_out.alu_src_a;
    assign bus.alu_src_b     = w_out.alu_src_b;
    assign bus.pc_src        = w_out.pc_src;
    assign bus.pc_write      = w_out.pc_write;
    assign bus.pc_write_cond = w_out.pc_write_cond;
    assign bus.iord          = w_out.iord;
    assign bus.mem_req       = w_out.mem_req;
    assign bus.mem_we        = w_out.mem_we;
    assign bus.ir_write      = w_out.ir_write;
    assign bus.reg_write     = w_out.reg_write;
    assign bus.reg_dst       = w_out.reg_dst;
    assign bus.mem_to_reg    = w_out.mem_to_reg;
    assign bus.illegal_op    = w_out.illegal_op;
    assign bus.bus_error     = r_bus_error;
    assign bus.state         = r_state;

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_out.ir_write) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.instr_cnt = r_instr_cnt;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed self-checking bench for multicycle_control (MEM_TIMEOUT = 16).
// Each cycle's full output vector is compared against a hand-written value.
// -----------------------------------------------------------------------------
module tb_multicycle_control;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multicycle_control_if bus();

    multicycle_control #(
        .MEM_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag bits of the packed output vector.
    localparam logic [10:0] PCW  = 11'h400;
    localparam logic [10:0] PCWC = 11'h200;
    localparam logic [10:0] IORD = 11'h100;
    localparam logic [10:0] MREQ = 11'h080;
    localparam logic [10:0] MWE  = 11'h040;
    localparam logic [10:0] IRW  = 11'h020;
    localparam logic [10:0] RW   = 11'h010;
    localparam logic [10:0] RDST = 11'h008;
    localparam logic [10:0] M2R  = 11'h004;
    localparam logic [10:0] ILL  = 11'h002;
    localparam logic [10:0] BERR = 11'h001;

    function automatic logic [22:0] mk(input logic [3:0] st, input logic [2:0] op,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic [10:0] fl);
        return {st, op, sa, sb, ps, fl};
    endfunction

    function automatic logic [22:0] obs();
        return {bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_req, bus.mem_we,
                bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.illegal_op, bus.bus_error};
    endfunction

    // Common expected vectors.
    logic [22:0] v_fetch_go;
    logic [22:0] v_fetch_wait;
    logic [22:0] v_decode;
    initial begin
        v_fetch_go   = mk(4'd0, 3'd0, 1'b0, 2'd1, 2'd0, MREQ | IRW | PCW);
        v_fetch_wait = mk(4'd0, 3'd0, 1'b0, 2'd1, 2'd0, MREQ);
        v_decode     = mk(4'd1, 3'd0, 1'b0, 2'd3, 2'd0, 11'h000);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with rst_n released.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        got = obs(); checks++;
        if (got !== 23'h0) begin
            failures++; $display("FAIL reset_low: got %h want %h", got, 23'h0);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        got = obs(); checks++;
        if (got !== v_fetch_go) begin
            failures++; $display("FAIL reset_release: got %h want %h", got, v_fetch_go);
        end
        next_cycle();
        #1;
        got = obs(); checks++;
        if (got !== v_decode) begin
            failures++; $display("FAIL reset_decode: got %h want %h", got, v_decode);
        end
    endtask

    task automatic test_rtype();
        logic [22:0] want[4];
        logic [22:0] got;
        want[0] = v_fetch_go;
        want[1] = v_decode;
        want[2] = mk(4'd2, 3'b111, 1'b1, 2'd0, 2'd0, 11'h000);
        want[3] = mk(4'd3, 3'd0, 1'b0, 2'd0, 2'd0, RW | RDST);
        bus.opcode = 6'h00; bus.mem_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            #1; got = obs(); checks++;
            if (got !== want[i]) begin
                failures++; $display("FAIL rtype c%0d: got %h want %h", i, got, want[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_itype();
        logic [5:0]  ops[4];
        logic [2:0]  aops[4];
        logic [22:0] want[4];
        logic [22:0] got;
        ops  = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
        aops = '{3'd0, 3'd4, 3'd2, 3'd3};
        bus.mem_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            bus.opcode = ops[k];
            want[0] = v_fetch_go;
            want[1] = v_decode;
            want[2] = mk(4'd4, aops[k], 1'b1, 2'd2, 2'd0, 11'h000);
            want[3] = mk(4'd5, 3'd0, 1'b0, 2'd0, 2'd0, RW);
            for (int i = 0; i < 4; i++) begin
                #1; got = obs(); checks++;
                if (got !== want[i]) begin
                    failures++;
                    $display("FAIL itype op%h c%0d: got %h want %h", ops[k], i, got, want[i]);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy[9];
        logic [22:0] want[9];
        logic [22:0] got;
        rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        want[0] = v_fetch_go;
        want[1] = v_decode;
        want[2] = mk(4'd6, 3'd0, 1'b1, 2'd2, 2'd0, 11'h000);
        for (int i = 3; i < 7; i++) want[i] = mk(4'd7, 3'd0, 1'b0, 2'd0, 2'd0, IORD | MREQ);
        want[7] = mk(4'd8, 3'd0, 1'b0, 2'd0, 2'd0, RW | M2R);
        want[8] = v_fetch_wait;
        bus.opcode = 6'h23; bus.mem_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = rdy[i];
            #1; got = obs(); checks++;
            if (got !== want[i]) begin
                failures++; $display("FAIL lw c%0d: got %h want %h", i, got, want[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_sw();
        logic [22:0] want[5];
        logic [22:0] got;
        want[0] = v_fetch_go;
        want[1] = v_decode;
        want[2] = mk(4'd6, 3'd0, 1'b1, 2'd2, 2'd0, 11'h000);
        want[3] = mk(4'd7, 3'd0, 1'b0, 2'd0, 2'd0, IORD | MREQ | MWE);
        want[4] = v_fetch_go;
        bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            #1; got = obs(); checks++;
            if (got !== want[i]) begin
                failures++; $display("FAIL sw c%0d: got %h want %h", i, got, want[i]);
            end
            next_cycle();
        end
    endtask

    // beq, j and illegal opcode back to back; each returns to FETCH.
    task automatic test_branch_jump_illegal();
        logic [5:0]  ops[3];
        logic [22:0] mid[3];
        logic [22:0] want;
        logic [22:0] got;
        ops    = '{6'h04, 6'h02, 6'h3F};
        mid[0] = mk(4'd9, 3'd1, 1'b1, 2'd0, 2'd1, PCWC);
        mid[1] = mk(4'd10, 3'd0, 1'b0, 2'd0, 2'd2, PCW);
        mid[2] = mk(4'd11, 3'd0, 1'b0, 2'd0, 2'd0, ILL);
        bus.zero = 1'b1; bus.mem_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            bus.opcode = ops[k];
            for (int i = 0; i < 3; i++) begin
                want = (i == 0) ? v_fetch_go : (i == 1) ? v_decode : mid[k];
                #1; got = obs(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL ctl op%h c%0d: got %h want %h", ops[k], i, got, want);
                end
                next_cycle();
            end
        end
        #1; got = obs(); checks++;
        if (got !== v_fetch_go) begin
            failures++; $display("FAIL ctl refetch: got %h want %h", got, v_fetch_go);
        end
        next_cycle();
        bus.zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops[10];
        logic [22:0] want[10];
        logic [22:0] got;
        for (int i = 0; i < 10; i++) ops[i] = (i < 4) ? 6'h00 : 6'h23;
        want[0] = v_fetch_go;
        want[1] = v_decode;
        want[2] = mk(4'd2, 3'b111, 1'b1, 2'd0, 2'd0, 11'h000);
        want[3] = mk(4'd3, 3'd0, 1'b0, 2'd0, 2'd0, RW | RDST);
        want[4] = v_fetch_go;
        want[5] = v_decode;
        want[6] = mk(4'd6, 3'd0, 1'b1, 2'd2, 2'd0, 11'h000);
        want[7] = mk(4'd7, 3'd0, 1'b0, 2'd0, 2'd0, IORD | MREQ);
        want[8] = mk(4'd8, 3'd0, 1'b0, 2'd0, 2'd0, RW | M2R);
        want[9] = v_fetch_go;
        bus.mem_ready = 1'b1; bus.opcode = ops[0];
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            bus.opcode = ops[i];
            #1; got = obs(); checks++;
            if (got !== want[i]) begin
                failures++; $display("FAIL b2b c%0d: got %h want %h", i, got, want[i]);
            end
            next_cycle();
        end
    endtask

    // Expects to start at the first of 16 stalled FETCH cycles.
    task automatic fetch_timeout_seq(input string name);
        logic [22:0] got;
        logic [22:0] want;
        for (int i = 0; i < 18; i++) begin
            want = (i == 16) ? mk(4'd0, 3'd0, 1'b0, 2'd1, 2'd0, MREQ | BERR) : v_fetch_wait;
            #1; got = obs(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL %s c%0d: got %h want %h", name, i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        logic [22:0] got;
        logic [22:0] want;
        bus.opcode = 6'h00; bus.mem_ready = 1'b0;
        apply_reset();
        fetch_timeout_seq("fetch_to");
        // mem_ready on the 16th wait cycle completes normally.
        apply_reset();
        for (int i = 0; i < 15; i++) next_cycle();
        bus.mem_ready = 1'b1;
        #1; got = obs(); checks++;
        if (got !== v_fetch_go) begin
            failures++; $display("FAIL ready_at_limit: got %h want %h", got, v_fetch_go);
        end
        next_cycle();
        bus.mem_ready = 1'b0;
        #1; got = obs(); checks++;
        if (got !== v_decode) begin
            failures++; $display("FAIL ready_at_limit_next: got %h want %h", got, v_decode);
        end
        // lw stalls 16 cycles in MEM, then abandons to FETCH with no write-back.
        bus.opcode = 6'h23; bus.mem_ready = 1'b1;
        apply_reset();
        next_cycle(); next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
        for (int i = 0; i < 17; i++) begin
            want = (i == 16) ? mk(4'd0, 3'd0, 1'b0, 2'd1, 2'd0, MREQ | BERR)
                             : mk(4'd7, 3'd0, 1'b0, 2'd0, 2'd0, IORD | MREQ);
            #1; got = obs(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL mem_to c%0d: got %h want %h", i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [22:0] got;
        logic [22:0] want;
        bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
        apply_reset();
        next_cycle(); next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle(); next_cycle(); next_cycle();
        want = mk(4'd7, 3'd0, 1'b0, 2'd0, 2'd0, IORD | MREQ | MWE);
        #1; got = obs(); checks++;
        if (got !== want) begin
            failures++; $display("FAIL rst_mem_pre: got %h want %h", got, want);
        end
        #1; rst_n = 1'b0;
        #1; got = obs(); checks++;
        if (got !== 23'h0) begin
            failures++; $display("FAIL rst_mem_low: got %h want %h", got, 23'h0);
        end
        next_cycle();
        rst_n = 1'b1;
        // Timeout must count a full 16 cycles again from the fresh FETCH.
        fetch_timeout_seq("rst_mem_after");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_lw_wait();
        test_sw();
        test_branch_jump_illegal();
        test_back_to_back();
        test_timeout();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
